// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit.
// Accepts the registered M-stage access, issues one request at a time on a
// request/response data-memory port, formats store lanes/strobes and
// extends load data. The pipeline is held with stall_M while an access is
// in flight; misaligned or illegal accesses fault without touching memory.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead_M,
  input  logic              memWrite_M,
  input  logic [2:0]        mode_M,
  input  logic [31:0]       alu_rsl_M,
  input  logic [31:0]       write_Data_M,
  output logic              stall_M,
  output logic [31:0]       load_data_M,
  output logic              load_valid_M,
  output logic              access_fault_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Access attributes captured at issue and held for the whole transaction.
  logic [2:0] mode_p1;
  logic [1:0] off_p1;

  // Decode of the instruction currently presented in M.
  logic              access;
  logic              is_store;
  logic              mode_ok;
  logic              misalign;
  logic              legal;
  logic              fault_c;
  logic              issue;
  logic [ADDR_W-1:0] addr_aligned;

  // Replicate the store operand across every lane it may land in.
  function automatic logic [31:0] fmt_wdata(input logic [1:0] size,
                                            input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Byte enables for the addressed lane(s); offsets are already aligned.
  function automatic logic [3:0] fmt_wstrb(input logic [1:0] size,
                                           input logic [1:0] off);
    logic [3:0] r;
    case (size)
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = 4'b0011 << off;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] fmt_load(input logic [2:0]  mode,
                                           input logic [1:0]  off,
                                           input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (mode)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Classify the M-stage access: store has priority, stores cannot use
  // the unsigned load encodings, and halves/words must be naturally aligned.
  always_comb begin
    access   = memRead_M | memWrite_M;
    is_store = memWrite_M;
    case (mode_M)
      3'b000, 3'b001, 3'b010: mode_ok = 1'b1;
      3'b100, 3'b101:         mode_ok = ~is_store;
      default:                mode_ok = 1'b0;
    endcase
    misalign = ((mode_M[1:0] == 2'b01) &  alu_rsl_M[0]) |
               ((mode_M[1:0] == 2'b10) & (alu_rsl_M[1:0] != 2'b00));
    legal    = access & mode_ok & ~misalign;
    fault_c  = access & ~legal;
  end

  // Word-aligned request address taken from the low ADDR_W address bits.
  always_comb begin
    addr_aligned      = ADDR_W'(alu_rsl_M);
    addr_aligned[1:0] = 2'b00;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle pipeline handshake outputs. Reset suppresses
  // every pulse so an interrupted load never reports completion.
  always_comb begin
    state_nxt      = state;
    stall_M        = 1'b0;
    load_valid_M   = 1'b0;
    access_fault_M = 1'b0;
    issue          = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          stall_M   = 1'b1;
          issue     = 1'b1;
          state_nxt = REQ;
        end else if (fault_c) begin
          access_fault_M = 1'b1;
        end
      end
      REQ: begin
        stall_M = 1'b1;
        if (mem_ready) state_nxt = DONE;
      end
      DONE: begin
        load_valid_M = ~mem_we;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      stall_M        = 1'b0;
      load_valid_M   = 1'b0;
      access_fault_M = 1'b0;
      issue          = 1'b0;
    end
  end

  // Request port registers: fields latch once at issue and stay frozen
  // through REQ; mem_req is a pure flop so mem_ready never reaches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mode_p1   <= '0;
      off_p1    <= '0;
    end else begin
      mem_req <= (state_nxt == REQ);
      if (issue) begin
        mem_we    <= is_store;
        mem_addr  <= addr_aligned;
        mem_wdata <= is_store ? fmt_wdata(mode_M[1:0], write_Data_M) : 32'd0;
        mem_wstrb <= is_store ? fmt_wstrb(mode_M[1:0], alu_rsl_M[1:0]) : 4'b0000;
        mode_p1   <= mode_M;
        off_p1    <= alu_rsl_M[1:0];
      end
    end
  end

  // ---- stage boundary: memory response -> formatted load result ----
  // Load result register; holds until the next load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_data_M <= '0;
    end else if ((state == REQ) && mem_ready && !mem_we) begin
      load_data_M <= fmt_load(mode_p1, off_p1, mem_rdata);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, wait states, faults,
// reset during a request and back-to-back accesses.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead_M;
  logic        memWrite_M;
  logic [2:0]  mode_M;
  logic [31:0] alu_rsl_M;
  logic [31:0] write_Data_M;
  logic        stall_M;
  logic [31:0] load_data_M;
  logic        load_valid_M;
  logic        access_fault_M;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Results of the most recent run_access call.
  int          r_cycles, r_stall, r_req, r_fault, r_lv, r_lv_k;
  int          r_first_req, r_last_req;
  logic        r_done;
  logic [31:0] r_ld, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;

  int          lw_last_req, sw_first_req;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .memRead_M      (memRead_M),
    .memWrite_M     (memWrite_M),
    .mode_M         (mode_M),
    .alu_rsl_M      (alu_rsl_M),
    .write_Data_M   (write_Data_M),
    .stall_M        (stall_M),
    .load_data_M    (load_data_M),
    .load_valid_M   (load_valid_M),
    .access_fault_M (access_fault_M),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Present one instruction in M and hold it until the cycle where stall_M
  // is low (its retirement cycle). Memory answers after 'delay' REQ cycles.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int delay, input logic [31:0] rdata);
    r_cycles = 0; r_stall = 0; r_req = 0; r_fault = 0; r_lv = 0; r_lv_k = -1;
    r_first_req = -1; r_last_req = -1; r_done = 1'b0;
    r_ld = '0; r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      memRead_M    = rd;
      memWrite_M   = wr;
      mode_M       = mode;
      alu_rsl_M    = addr;
      write_Data_M = wd;
      if (mem_req && (r_req >= delay)) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hA5A5_5A5A;
      end
      #1;
      r_cycles++;
      if (stall_M) r_stall++;
      if (mem_req) begin
        if (r_req == 0) r_first_req = cyc;
        r_last_req = cyc;
        r_req++;
        r_addr  = mem_addr;
        r_wdata = mem_wdata;
        r_wstrb = mem_wstrb;
        r_we    = mem_we;
      end
      if (access_fault_M) r_fault++;
      if (load_valid_M) begin
        r_lv++;
        r_lv_k = k;
        r_ld   = load_data_M;
      end
      if (!stall_M) begin
        r_done = 1'b1;
        break;
      end
    end
    chk("retired", r_done, 1'b1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    memRead_M  = 1'b0;
    memWrite_M = 1'b0;
    mem_ready  = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    memRead_M = 1'b0; memWrite_M = 1'b0; mode_M = 3'b000;
    alu_rsl_M = '0; write_Data_M = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_req",   mem_req, 0);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_ld",    load_data_M, 0);
    chk("rst_lv",    load_valid_M, 0);
    chk("rst_fault", access_fault_M, 0);
    chk("rst_stall", stall_M, 0);

    // LW aligned, memory ready in the first REQ cycle.
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("lw_cycles", r_cycles, 3);
    chk("lw_stall",  r_stall, 2);
    chk("lw_req",    r_req, 1);
    chk("lw_addr",   r_addr, 32'h100);
    chk("lw_wstrb",  r_wstrb, 4'b0000);
    chk("lw_we",     r_we, 0);
    chk("lw_lv",     r_lv, 1);
    chk("lw_lv_cyc", r_lv_k, 2);
    chk("lw_data",   r_ld, 32'hDEADBEEF);
    chk("lw_fault",  r_fault, 0);

    // Byte/half extraction from 0x80FF0000.
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF0000);
    chk("lb_data", r_ld, 32'hFFFFFF80);
    chk("lb_addr", r_addr, 32'h100);
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF0000);
    chk("lbu_data", r_ld, 32'h00000080);
    run_access(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF0000);
    chk("lh_data", r_ld, 32'hFFFF80FF);
    chk("lh_lv",   r_lv, 1);

    // Stores; SH with three wait states.
    run_access(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 32'h0);
    chk("sb_wdata", r_wdata, 32'hABABABAB);
    chk("sb_wstrb", r_wstrb, 4'b0010);
    chk("sb_addr",  r_addr, 32'h200);
    chk("sb_we",    r_we, 1);
    chk("sb_lv",    r_lv, 0);
    run_access(0, 1, 3'b001, 32'h202, 32'h00001234, 3, 32'h0);
    chk("sh_wdata", r_wdata, 32'h12341234);
    chk("sh_wstrb", r_wstrb, 4'b1100);
    chk("sh_req",   r_req, 4);
    chk("sh_stall", r_stall, 5);
    chk("ld_hold",  load_data_M, 32'hFFFF80FF);

    // Faults: no request, no stall, one-cycle fault.
    run_access(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    chk("flw_fault",  r_fault, 1);
    chk("flw_req",    r_req, 0);
    chk("flw_stall",  r_stall, 0);
    chk("flw_cycles", r_cycles, 1);
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    chk("fm3_fault", r_fault, 1);
    chk("fm3_req",   r_req, 0);
    run_access(0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    chk("fsu_fault", r_fault, 1);
    idle_cycle();
    chk("fault_clr", access_fault_M, 0);

    // Both read and write set: handled as a store.
    run_access(1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h11111111);
    chk("both_we",    r_we, 1);
    chk("both_wstrb", r_wstrb, 4'b1111);
    chk("both_wdata", r_wdata, 32'hCAFEF00D);
    chk("both_lv",    r_lv, 0);
    chk("both_ld",    load_data_M, 32'hFFFF80FF);

    // Reset while a load waits in REQ.
    @(negedge clk);
    memRead_M = 1'b1; memWrite_M = 1'b0; mode_M = 3'b010; alu_rsl_M = 32'h500;
    mem_ready = 1'b0;
    #1 chk("rm_idle_stall", stall_M, 1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("rm_in_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; memRead_M = 1'b0;
    #1;
    chk("rm_req",   mem_req, 0);
    chk("rm_stall", stall_M, 0);
    chk("rm_lv",    load_valid_M, 0);
    chk("rm_ld",    load_data_M, 0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("rm_lv_after",  load_valid_M, 0);
      chk("rm_req_after", mem_req, 0);
    end

    // Back-to-back LW then SW.
    run_access(1, 0, 3'b010, 32'h400, 32'h0, 0, 32'h11223344);
    lw_last_req = r_last_req;
    chk("b2b_lw_req",  r_req, 1);
    chk("b2b_lw_data", r_ld, 32'h11223344);
    run_access(0, 1, 3'b010, 32'h404, 32'h55667788, 0, 32'h0);
    sw_first_req = r_first_req;
    chk("b2b_sw_req",   r_req, 1);
    chk("b2b_sw_addr",  r_addr, 32'h404);
    chk("b2b_sw_wdata", r_wdata, 32'h55667788);
    chk("b2b_sw_wstrb", r_wstrb, 4'b1111);
    chk("b2b_gap",      sw_first_req - lw_last_req, 3);
    idle_cycle();
    chk("b2b_no_dup", mem_req, 0);
    chk("b2b_ld",     load_data_M, 32'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
